// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: PC register, request/ready fetch FSM and IF/ID register.
// Optional MISALIGN_TRAP_EN: misaligned branch targets redirect to TRAP_VEC and set fetch_misalign.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  input  logic [31:0] adder_sum,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH    = 2'd1;
  localparam logic [1:0] ST_STALLED  = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_sum_q, buf_sum_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        redir_misalign;
  logic [31:0] redir_pc;

  // With the trap disabled the low target bits are simply masked off.
  always_comb begin
    redir_misalign = TRAP_EN && (branch_target[1:0] != 2'b00);
    redir_pc       = redir_misalign ? TRAP_VEC : {branch_target[31:2], 2'b00};
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    buf_pc_d        = buf_pc_q;
    buf_instr_d     = buf_instr_q;
    buf_sum_d       = buf_sum_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;

    // A branch wins in every state: flush IF/ID, drop any buffered fetch.
    if (branch_taken) begin
      pc_d         = redir_pc;
      ifid_valid_d = 1'b0;
      state_d      = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (stall) begin
            if (imem_ready) begin
              buf_pc_d    = pc_q;
              buf_instr_d = imem_rdata;
              buf_sum_d   = adder_sum;
              state_d     = ST_STALLED;
            end
          end else if (imem_ready) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = pc_q;
            ifid_instr_d    = imem_rdata;
            ifid_pc_plus4_d = adder_sum;
            pc_d            = adder_sum;
          end else begin
            ifid_valid_d = 1'b0;
          end
        end
        ST_STALLED: begin
          if (!stall) begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = buf_pc_q;
            ifid_instr_d    = buf_instr_q;
            ifid_pc_plus4_d = buf_sum_q;
            pc_d            = buf_sum_q;
            state_d         = ST_FETCH;
          end
        end
        default: begin
          ifid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      buf_pc_q        <= 32'h0;
      buf_instr_q     <= 32'h0;
      buf_sum_q       <= 32'h0;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'h0;
      ifid_instr_q    <= 32'h0;
      ifid_pc_plus4_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      buf_pc_q        <= buf_pc_d;
      buf_instr_q     <= buf_instr_d;
      buf_sum_q       <= buf_sum_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Sticky until reset.
  always_comb begin
    misalign_d = misalign_q | (branch_taken & redir_misalign);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;
`endif

  assign adder_a       = pc_q;
  assign adder_b       = PC_INC;
  assign imem_addr     = pc_q;
  assign imem_req      = (state_q == ST_FETCH);
  assign ifid_valid    = ifid_valid_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed scoreboard bench for pc_fetch_stage; a second instance covers a wrapping RESET_PC.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;

  logic [31:0] d0_adder_a, d0_adder_b, d0_adder_sum, d0_imem_addr, d0_imem_rdata;
  logic [31:0] d0_ifid_pc, d0_ifid_instr, d0_ifid_pc_plus4;
  logic        d0_imem_req, d0_ifid_valid;
  logic [31:0] d1_adder_a, d1_adder_b, d1_adder_sum, d1_imem_addr, d1_imem_rdata;
  logic [31:0] d1_ifid_pc, d1_ifid_instr, d1_ifid_pc_plus4;
  logic        d1_imem_req, d1_ifid_valid;
`ifdef MISALIGN_TRAP_EN
  logic        d0_fetch_misalign, d1_fetch_misalign;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
  } ifid_t;

  ifid_t       sb_q[$];
  logic        pop_pending;
  logic [31:0] held_pc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Environment: ideal incrementer and a memory whose word is a function of its address.
  assign d0_adder_sum  = d0_adder_a + d0_adder_b;
  assign d0_imem_rdata = instr_of(d0_imem_addr);
  assign d1_adder_sum  = d1_adder_a + d1_adder_b;
  assign d1_imem_rdata = instr_of(d1_imem_addr);

  pc_fetch_stage dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .adder_a       (d0_adder_a),
    .adder_b       (d0_adder_b),
    .adder_sum     (d0_adder_sum),
    .imem_req      (d0_imem_req),
    .imem_addr     (d0_imem_addr),
    .imem_rdata    (d0_imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_valid    (d0_ifid_valid),
    .ifid_pc       (d0_ifid_pc),
    .ifid_instr    (d0_ifid_instr),
    .ifid_pc_plus4 (d0_ifid_pc_plus4)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misalign(d0_fetch_misalign)
`endif
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .adder_a       (d1_adder_a),
    .adder_b       (d1_adder_b),
    .adder_sum     (d1_adder_sum),
    .imem_req      (d1_imem_req),
    .imem_addr     (d1_imem_addr),
    .imem_rdata    (d1_imem_rdata),
    .imem_ready    (imem_ready),
    .ifid_valid    (d1_ifid_valid),
    .ifid_pc       (d1_ifid_pc),
    .ifid_instr    (d1_ifid_instr),
    .ifid_pc_plus4 (d1_ifid_pc_plus4)
`ifdef MISALIGN_TRAP_EN
    ,
    .fetch_misalign(d1_fetch_misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs; push the IF/ID entry this cycle should produce, then step past the edge.
  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t,
                               input logic r, input logic push, input logic [31:0] ppc);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    imem_ready    = r;
    if (push) sb_q.push_back('{pc: ppc, instr: instr_of(ppc), plus4: ppc + 32'd4});
    pop_pending = push;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_req,
                             input logic [31:0] exp_addr, input logic exp_valid);
    ifid_t e;
    chk({tag, ".req"},   {31'b0, d0_imem_req},   {31'b0, exp_req});
    chk({tag, ".addr"},  d0_imem_addr,           exp_addr);
    chk({tag, ".valid"}, {31'b0, d0_ifid_valid}, {31'b0, exp_valid});
    if (pop_pending) begin
      chk({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({tag, ".ifid_pc"},    d0_ifid_pc,       e.pc);
        chk({tag, ".ifid_instr"}, d0_ifid_instr,    e.instr);
        chk({tag, ".ifid_plus4"}, d0_ifid_pc_plus4, e.plus4);
        held_pc = e.pc;
      end
    end else if (exp_valid) begin
      chk({tag, ".hold_pc"}, d0_ifid_pc, held_pc);
    end
    pop_pending = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_ready    = 1'b1;
    pop_pending   = 1'b0;
    held_pc       = 32'h0;
    $display("[TB] start");

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req",        {31'b0, d0_imem_req},   32'd0);
    chk("rst.addr",       d0_imem_addr,           32'h0);
    chk("rst.valid",      {31'b0, d0_ifid_valid}, 32'd0);
    chk("rst.ifid_pc",    d0_ifid_pc,             32'h0);
    chk("rst.ifid_instr", d0_ifid_instr,          32'h0);
    chk("rst.ifid_plus4", d0_ifid_pc_plus4,       32'h0);
    chk("rst.adder_b",    d0_adder_b,             32'd4);
    chk("rst.d1_addr",    d1_imem_addr,           32'hFFFF_FFF8);
`ifdef MISALIGN_TRAP_EN
    chk("rst.misalign",   {31'b0, d0_fetch_misalign}, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    chk("idle.req", {31'b0, d0_imem_req}, 32'd0);

    // Back-to-back fetch with ready held high.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("f0", 1'b1, 32'h0, 1'b0);
    chk("f0.adder_a", d0_adder_a, 32'h0);
    chk("f0.d1_addr", d1_imem_addr, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    checkOutput("f1", 1'b1, 32'h4, 1'b1);
    chk("f1.d1_addr",    d1_imem_addr, 32'hFFFF_FFFC);
    chk("f1.d1_ifid_pc", d1_ifid_pc,   32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4);
    checkOutput("f2", 1'b1, 32'h8, 1'b1);
    chk("f2.d1_addr",       d1_imem_addr,     32'h0);
    chk("f2.d1_ifid_pc",    d1_ifid_pc,       32'hFFFF_FFFC);
    chk("f2.d1_ifid_plus4", d1_ifid_pc_plus4, 32'h0);

    // Stall for three cycles while the word at pc=8 is ready.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st0", 1'b0, 32'h8, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st1", 1'b0, 32'h8, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st2", 1'b0, 32'h8, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8);
    checkOutput("st_rel", 1'b1, 32'hC, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC);
    checkOutput("f3", 1'b1, 32'h10, 1'b1);

    // Branch to 0x40 from pc=0x10, then two not-ready cycles.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
    checkOutput("br0", 1'b0, 32'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("br1", 1'b1, 32'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("bub0", 1'b1, 32'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("bub1", 1'b1, 32'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
    checkOutput("f40", 1'b1, 32'h44, 1'b1);

    // Enter STALLED with a buffered word, then reset asynchronously.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st44", 1'b0, 32'h44, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.addr",  d0_imem_addr,           32'h0);
    chk("arst.req",   {31'b0, d0_imem_req},   32'd0);
    chk("arst.valid", {31'b0, d0_ifid_valid}, 32'd0);
    chk("arst.ifid_pc", d0_ifid_pc,           32'h0);
    #2;
    rst_n = 1'b1;
    stall = 1'b0;
    held_pc = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("ar_f0", 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    checkOutput("ar_f1", 1'b1, 32'h4, 1'b1);

    // Misaligned target, then a second branch while in REDIRECT.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("mis", 1'b0, 32'h100, 1'b0);
    chk("mis.flag", {31'b0, d0_fetch_misalign}, 32'd1);
`else
    checkOutput("mis", 1'b0, 32'h40, 1'b0);
`endif
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
    checkOutput("rr0", 1'b0, 32'h80, 1'b0);
`ifdef MISALIGN_TRAP_EN
    chk("rr0.flag", {31'b0, d0_fetch_misalign}, 32'd1);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rr1", 1'b1, 32'h80, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    checkOutput("f80", 1'b1, 32'h84, 1'b1);

    // Branch arriving while STALLED drops the buffer.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("st84", 1'b0, 32'h84, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    checkOutput("stbr", 1'b0, 32'h200, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("f200", 1'b1, 32'h200, 1'b0);

    chk("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch front end of the pipelined core. Holds the program counter and drives the 32-bit incrementer adder with operands PC and PC_INC. Consumes the adder's sum as the sequential next PC.
- Issues requests on a request/ready instruction-memory interface.
- Loads the IF/ID pipeline register, with stall, branch-redirect and bubble handling.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 32'd4, constant driven on adder_b.
- TRAP_VEC, 32'h0000_0100, redirect target for a misaligned branch. Used only when MISALIGN_TRAP_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold. PC and IF/ID are frozen while high.
- branch_taken  in  1  redirect request, valid for one cycle.
- branch_target  in  32  redirect address.
- adder_a  out  32  incrementer operand A; equals pc.
- adder_b  out  32  incrementer operand B; equals PC_INC.
- adder_sum  in  32  incrementer result, i.e. pc+PC_INC (combinational return).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_rdata  in  32  instruction word, valid when imem_ready.
- imem_ready  in  1  memory accepts the request and returns data in the same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  32  PC of the instruction in IF/ID.
- ifid_instr  out  32  instruction word in IF/ID.
- ifid_pc_plus4  out  32  adder_sum captured together with the instruction.
- fetch_misalign  out  1  sticky misaligned-branch flag. Present only with MISALIGN_TRAP_EN.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; state=IDLE.
  - ifid_valid=0; ifid_pc/ifid_instr/ifid_pc_plus4=0.
  - Internal buffer cleared; imem_req=0.
  - A reset arriving mid-operation discards any in-flight or buffered fetch.
- Combinational outputs: adder_a=pc, adder_b=PC_INC, imem_addr=pc at all times.
- imem_req is 1 only in FETCH. imem_addr is stable while imem_req=1 and imem_ready=0.
- Event priority each cycle: branch_taken > stall > imem_ready.
- IDLE:
  - Entered from reset; imem_req=0.
  - Next cycle goes to FETCH, unless branch_taken, which loads pc and goes to REDIRECT.
- FETCH, branch_taken:
  - pc<=branch_target with [1:0] forced to 0; ifid_valid<=0.
  - Ready data is discarded; go to REDIRECT.
- FETCH, stall=1 and imem_ready=1:
  - Capture {pc, imem_rdata, adder_sum} into the buffer; go to STALLED.
  - pc and IF/ID unchanged.
- FETCH, stall=1 and imem_ready=0: hold everything; keep requesting.
- FETCH, stall=0 and imem_ready=1:
  - IF/ID<={pc, imem_rdata, adder_sum}; ifid_valid<=1; pc<=adder_sum.
  - Stay in FETCH; back-to-back, one instruction per cycle.
- FETCH, stall=0 and imem_ready=0: ifid_valid<=0 (bubble); pc held.
- STALLED:
  - imem_req=0.
  - While stall=1: hold everything.
  - On stall=0: IF/ID<=buffer; ifid_valid<=1; pc<=buffered sum; go to FETCH.
  - On branch_taken: drop the buffer; pc<=target; ifid_valid<=0; go to REDIRECT.
- REDIRECT:
  - imem_req=0 for exactly one cycle, which abandons the old request; then go to FETCH.
  - If stall=1: ifid_valid is still cleared (a flush overrides the hold).
  - A further branch_taken reloads pc and stays in REDIRECT.
- Latency:
  - First request one cycle after reset release.
  - Instruction appears in IF/ID on the edge after the imem_ready cycle.
  - Redirect-to-first-new-request takes 2 cycles.
- Arithmetic: pc wraps modulo 2^32 through the adder (0xFFFF_FFFC+4 gives 0); no overflow flag.
- ifid_* outputs change only on clock edges; none is driven combinationally from the inputs.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A branch_taken with branch_target[1:0]!=0 loads pc<=TRAP_VEC instead and sets fetch_misalign=1.
  - fetch_misalign stays set until reset; the redirect path is otherwise identical.
- Undefined:
  - fetch_misalign port absent; target[1:0] silently masked to 0; TRAP_VEC unused.

Test Plan:
- Release reset, imem_ready=1 constant, instructions I0..I3 -> imem_addr 0,4,8,C on consecutive cycles; IF/ID shows (0,I0,4),(4,I1,8)... one per cycle; ifid_valid=0 on the first cycle.
- stall=1 for 3 cycles coinciding with a ready at pc=8 -> pc and IF/ID frozen; imem_req=0 in STALLED; on release IF/ID=(8,I2,C) and the next request is at C.
- branch_taken, target=0x40, during FETCH at pc=0x10 -> ifid_valid=0 next cycle; one cycle with imem_req=0; then request at 0x40.
- Reset RESET_PC=0xFFFF_FFF8, imem_ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; ifid_pc_plus4 for FFFF_FFFC equals 0.
- imem_ready low for 2 cycles, stall=0 -> two bubbles (ifid_valid=0); imem_addr held; rst_n pulsed low while in STALLED -> buffer discarded, pc=RESET_PC, state IDLE.
- With MISALIGN_TRAP_EN, branch to 0x42 -> next request at 0x100 and fetch_misalign=1 held until reset; without the macro -> next request at 0x40.
